// File: rtl/magnitude_comparator.sv
// Registered WIDTH-bit magnitude comparator with unsigned/two's-complement modes
// and 74x85-style cascade inputs; one-hot gt/lt/eq flags one cycle after in_valid.
module magnitude_comparator #(
   parameter int WIDTH    = 4,
   parameter int RESET_EQ = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic             gt_in,
   input  logic             lt_in,
   input  logic             eq_in,
   output logic             out_valid,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b
);

   localparam logic RST_EQ = (RESET_EQ != 0);

   logic             out_valid_d, out_valid_q;
   logic             a_gt_b_d, a_gt_b_q;
   logic             a_lt_b_d, a_lt_b_q;
   logic             a_eq_b_d, a_eq_b_q;
   logic [WIDTH-1:0] sign_mask;
   logic [WIDTH-1:0] a_key, b_key;

   // Flipping the sign bit maps two's-complement order onto unsigned order,
   // so one unsigned compare serves both modes.
   always_comb begin
      sign_mask            = '0;
      sign_mask[WIDTH-1]   = signed_mode;
      a_key                = a ^ sign_mask;
      b_key                = b ^ sign_mask;
   end

   always_comb begin
      out_valid_d = in_valid;
      a_gt_b_d    = a_gt_b_q;
      a_lt_b_d    = a_lt_b_q;
      a_eq_b_d    = a_eq_b_q;
      if (in_valid) begin
         a_gt_b_d = 1'b0;
         a_lt_b_d = 1'b0;
         a_eq_b_d = 1'b0;
         if (a_key > b_key)      a_gt_b_d = 1'b1;
         else if (a_key < b_key) a_lt_b_d = 1'b1;
         else if (eq_in)         a_eq_b_d = 1'b1;
         else if (gt_in)         a_gt_b_d = 1'b1;
         else if (lt_in)         a_lt_b_d = 1'b1;
         else                    a_eq_b_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         a_gt_b_q    <= 1'b0;
         a_lt_b_q    <= 1'b0;
         a_eq_b_q    <= RST_EQ;
      end else begin
         out_valid_q <= out_valid_d;
         a_gt_b_q    <= a_gt_b_d;
         a_lt_b_q    <= a_lt_b_d;
         a_eq_b_q    <= a_eq_b_d;
      end
   end

   assign out_valid = out_valid_q;
   assign a_gt_b    = a_gt_b_q;
   assign a_lt_b    = a_lt_b_q;
   assign a_eq_b    = a_eq_b_q;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Bench for magnitude_comparator: directed tables, an 8-bit chained pair,
// a 1-bit instance, and random traffic against an integer reference model.
module tb_magnitude_comparator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, sm, gt_in, lt_in, eq_in;
   logic [3:0] a, b;
   logic       ov, gt, lt, eq;
   logic       w1_ov, w1_gt, w1_lt, w1_eq;

   // 8-bit chain: low nibble first, high nibble one cycle later
   logic       c_valid;
   logic [7:0] c_a, c_b;
   logic [3:0] hi_a_q, hi_b_q;
   logic       lo_ov, lo_gt, lo_lt, lo_eq;
   logic       hi_ov, hi_gt, hi_lt, hi_eq;

   int total = 0;
   int bad   = 0;

   logic       m_v, m_gt, m_lt, m_eq;      // 4-bit model state
   logic       m1_v, m1_gt, m1_lt, m1_eq;  // 1-bit model state

   magnitude_comparator #(.WIDTH(4), .RESET_EQ(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .signed_mode(sm),
      .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in),
      .out_valid(ov), .a_gt_b(gt), .a_lt_b(lt), .a_eq_b(eq));

   magnitude_comparator #(.WIDTH(1), .RESET_EQ(1)) dut_w1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0]), .b(b[0]), .signed_mode(sm),
      .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in),
      .out_valid(w1_ov), .a_gt_b(w1_gt), .a_lt_b(w1_lt), .a_eq_b(w1_eq));

   magnitude_comparator #(.WIDTH(4), .RESET_EQ(0)) dut_lo (
      .clk(clk), .rst(rst), .in_valid(c_valid), .a(c_a[3:0]), .b(c_b[3:0]), .signed_mode(1'b0),
      .gt_in(1'b0), .lt_in(1'b0), .eq_in(1'b1),
      .out_valid(lo_ov), .a_gt_b(lo_gt), .a_lt_b(lo_lt), .a_eq_b(lo_eq));

   magnitude_comparator #(.WIDTH(4), .RESET_EQ(0)) dut_hi (
      .clk(clk), .rst(rst), .in_valid(lo_ov), .a(hi_a_q), .b(hi_b_q), .signed_mode(1'b0),
      .gt_in(lo_gt), .lt_in(lo_lt), .eq_in(lo_eq),
      .out_valid(hi_ov), .a_gt_b(hi_gt), .a_lt_b(hi_lt), .a_eq_b(hi_eq));

   always @(posedge clk) begin
      hi_a_q <= c_a[7:4];
      hi_b_q <= c_b[7:4];
   end

   // Reference: operands as integers, then the cascade tie-break rules.
   function automatic logic [2:0] ref_cmp(input int av, input int bv,
                                          input logic g, input logic l, input logic e);
      if (av > bv) return 3'b100;
      if (av < bv) return 3'b010;
      if (e)       return 3'b001;
      if (g)       return 3'b100;
      if (l)       return 3'b010;
      return 3'b001;
   endfunction

   function automatic int val4(input logic [3:0] x, input logic s);
      int v;
      v = int'(x);
      if (s && x[3]) v = v - 16;
      return v;
   endfunction

   function automatic int val1(input logic x, input logic s);
      if (s) return x ? -1 : 0;
      return x ? 1 : 0;
   endfunction

   // Drive one cycle, advance both models, and sample 1 time unit after the edge.
   task automatic cycle(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv,
                        input logic s, input logic g, input logic l, input logic e);
      logic [2:0] f;
      rst = r; in_valid = v; a = av; b = bv; sm = s; gt_in = g; lt_in = l; eq_in = e;
      if (r) begin
         {m_v, m_gt, m_lt, m_eq}     = 4'b0000;
         {m1_v, m1_gt, m1_lt, m1_eq} = 4'b0001;
      end else if (v) begin
         f = ref_cmp(val4(av, s), val4(bv, s), g, l, e);
         m_v = 1'b1; {m_gt, m_lt, m_eq} = f;
         f = ref_cmp(val1(av[0], s), val1(bv[0], s), g, l, e);
         m1_v = 1'b1; {m1_gt, m1_lt, m1_eq} = f;
      end else begin
         m_v = 1'b0; m1_v = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      cycle(1, 1, 4'hF, 4'h0, 0, 0, 0, 1);
      cycle(1, 0, 4'h0, 4'h0, 0, 0, 0, 1);
      total++;
      if ({ov, gt, lt, eq} !== 4'b0000) begin
         bad++; $display("FAIL reset got=%b exp=0000", {ov, gt, lt, eq});
      end
      total++;
      if ({w1_ov, w1_gt, w1_lt, w1_eq} !== 4'b0001) begin
         bad++; $display("FAIL reset_eq1 got=%b exp=0001", {w1_ov, w1_gt, w1_lt, w1_eq});
      end
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 4'h3, 4'h1, 0, 0, 0, 1);
         total++;
         if ({ov, gt, lt, eq} !== 4'b0000) begin
            bad++; $display("FAIL reset_hold got=%b exp=0000", {ov, gt, lt, eq});
         end
      end
   endtask

   task automatic test_unsigned();
      logic [3:0] ta [5] = '{4'b0010, 4'b1011, 4'b1100, 4'b0011, 4'b0010};
      logic [3:0] tb [5] = '{4'b1011, 4'b1011, 4'b1001, 4'b0110, 4'b0010};
      logic [2:0] te [5] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, ta[i], tb[i], 0, 0, 0, 1);
         total++;
         if ({ov, gt, lt, eq} !== {1'b1, te[i]}) begin
            bad++; $display("FAIL unsigned[%0d] got=%b exp=%b", i, {ov, gt, lt, eq}, {1'b1, te[i]});
         end
      end
   endtask

   task automatic test_signed();
      logic [3:0] ta [4] = '{4'b0010, 4'b1100, 4'b1000, 4'b1111};
      logic [3:0] tb [4] = '{4'b1011, 4'b1001, 4'b0111, 4'b1111};
      logic [2:0] te [4] = '{3'b100, 3'b100, 3'b010, 3'b001};
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, ta[i], tb[i], 1, 0, 0, 1);
         total++;
         if ({ov, gt, lt, eq} !== {1'b1, te[i]}) begin
            bad++; $display("FAIL signed[%0d] got=%b exp=%b", i, {ov, gt, lt, eq}, {1'b1, te[i]});
         end
      end
   endtask

   task automatic test_cascade();
      logic [3:0] ta [4] = '{4'b0101, 4'b0101, 4'b0101, 4'b0100};
      logic [2:0] tc [4] = '{3'b100, 3'b010, 3'b000, 3'b100};  // {gt_in,lt_in,eq_in}
      logic [2:0] te [4] = '{3'b100, 3'b010, 3'b001, 3'b010};
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, ta[i], 4'b0101, 0, tc[i][2], tc[i][1], tc[i][0]);
         total++;
         if ({ov, gt, lt, eq} !== {1'b1, te[i]}) begin
            bad++; $display("FAIL cascade[%0d] got=%b exp=%b", i, {ov, gt, lt, eq}, {1'b1, te[i]});
         end
      end
   endtask

   task automatic test_gaps_reset();
      logic       tv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [3:0] ta [4] = '{4'h3, 4'h9, 4'h9, 4'h0};
      logic [3:0] tb [4] = '{4'h5, 4'h2, 4'h2, 4'h7};
      logic [3:0] te [4] = '{4'b1010, 4'b0010, 4'b1100, 4'b0100};
      for (int i = 0; i < 4; i++) begin
         cycle(0, tv[i], ta[i], tb[i], 0, 0, 0, 1);
         total++;
         if ({ov, gt, lt, eq} !== te[i]) begin
            bad++; $display("FAIL gap[%0d] got=%b exp=%b", i, {ov, gt, lt, eq}, te[i]);
         end
      end
      cycle(0, 1, 4'h1, 4'h2, 0, 0, 0, 1);
      cycle(1, 1, 4'hF, 4'h0, 0, 0, 0, 1);
      total++;
      if ({ov, gt, lt, eq} !== 4'b0000) begin
         bad++; $display("FAIL rst_priority got=%b exp=0000", {ov, gt, lt, eq});
      end
      cycle(0, 0, 4'hF, 4'h0, 0, 0, 0, 1);
      total++;
      if ({ov, gt, lt, eq} !== 4'b0000) begin
         bad++; $display("FAIL rst_drop got=%b exp=0000", {ov, gt, lt, eq});
      end
   endtask

   task automatic test_boundary();
      cycle(0, 1, 4'hF, 4'h0, 0, 0, 0, 1);
      total++;
      if ({ov, gt, lt, eq} !== 4'b1100) begin
         bad++; $display("FAIL ones_vs_zero got=%b exp=1100", {ov, gt, lt, eq});
      end
      cycle(0, 1, 4'hF, 4'h0, 1, 0, 0, 1);
      total++;
      if ({ov, gt, lt, eq} !== 4'b1010) begin
         bad++; $display("FAIL mode_switch got=%b exp=1010", {ov, gt, lt, eq});
      end
      cycle(0, 1, 4'h8, 4'h7, 1, 0, 0, 1);
      total++;
      if ({ov, gt, lt, eq} !== 4'b1010) begin
         bad++; $display("FAIL minneg_vs_maxpos got=%b exp=1010", {ov, gt, lt, eq});
      end
   endtask

   task automatic test_chain();
      logic [7:0] ta [3] = '{8'h5A, 8'h5B, 8'h6A};
      logic [7:0] tb [3] = '{8'h5B, 8'h5B, 8'h5F};
      logic [2:0] te [3] = '{3'b010, 3'b001, 3'b100};
      for (int i = 0; i < 3; i++) begin
         c_valid = 1'b1; c_a = ta[i]; c_b = tb[i];
         @(posedge clk); #1;
         c_valid = 1'b0;
         @(posedge clk); #1;
         total++;
         if ({hi_ov, hi_gt, hi_lt, hi_eq} !== {1'b1, te[i]}) begin
            bad++; $display("FAIL chain[%0d] got=%b exp=%b", i, {hi_ov, hi_gt, hi_lt, hi_eq}, {1'b1, te[i]});
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] ra, rb;
      logic       rv, rs;
      logic [2:0] rc;
      for (int i = 0; i < 300; i++) begin
         rv = ($urandom_range(0, 3) != 0);
         ra = 4'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom);
         rs = 1'($urandom);
         rc = 3'($urandom);
         cycle(0, rv, ra, rb, rs, rc[2], rc[1], rc[0]);
         total++;
         if ({ov, gt, lt, eq} !== {m_v, m_gt, m_lt, m_eq}) begin
            bad++; $display("FAIL random4[%0d] got=%b exp=%b", i, {ov, gt, lt, eq}, {m_v, m_gt, m_lt, m_eq});
         end
         total++;
         if ({w1_ov, w1_gt, w1_lt, w1_eq} !== {m1_v, m1_gt, m1_lt, m1_eq}) begin
            bad++; $display("FAIL random1[%0d] got=%b exp=%b", i, {w1_ov, w1_gt, w1_lt, w1_eq}, {m1_v, m1_gt, m1_lt, m1_eq});
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sm = 1'b0;
      gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1;
      c_valid = 1'b0; c_a = '0; c_b = '0;
      {m_v, m_gt, m_lt, m_eq} = 4'b0000;
      {m1_v, m1_gt, m1_lt, m1_eq} = 4'b0001;
      test_reset();
      test_unsigned();
      test_signed();
      test_cascade();
      test_gaps_reset();
      test_boundary();
      test_chain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
